prism_sp_unit_cmd_queue: RTL and testbench
==========================================

# prism_sp_unit_cmd_queue

Parametrised command tracker for PRISM stream-processor functional units. It accepts up to DEPTH outstanding commands from the CPU issue stage, each selecting one of NUM_CMDS engines. Commands are dispatched to their engines strictly in order, one at a time, and each is retired through the writeback handshake with its instruction ID. The block generalises the single-command busy/done flag to a queued, multi-engine, ID-tagged tracker with per-engine busy flags and protocol-error detection. Issue/writeback interface signals are flattened onto ports by the enclosing unit.

## Interface
Parameters:
- NUM_CMDS, 4, number of command engines (≥1)
- DEPTH, 4, outstanding-command capacity (≥2, power of two)
- ID_W, 3, instruction ID width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_new_request  in  1  issue stage presents an instruction
- issue_id  in  ID_W  ID of the presented instruction
- issue_cmd  in  NUM_CMDS  one-hot engine select; all-zero means not a command for this block
- issue_ready  out  1  queue can accept
- cmd_start  out  NUM_CMDS  one-cycle start pulse to the selected engine
- cmd_complete  in  NUM_CMDS  one-cycle completion pulse from an engine
- cmd_busy  out  NUM_CMDS  bit i high while any queued entry targets engine i
- wb_done  out  1  head command complete, awaiting retirement
- wb_id  out  ID_W  ID of head entry (valid while wb_done)
- wb_ack  in  1  writeback accepts head
- occupancy  out  $clog2(DEPTH)+1  entries queued
- protocol_err  out  1  sticky error flag

## Operation
- issue_ready = (occupancy != DEPTH), from registered count only; no pop-bypass.
- Accept = issue_new_request & issue_ready & issue_cmd exactly one-hot. Entry {id, cmd} is pushed at the tail.
- A request with ≥2 issue_cmd bits set is not pushed and sets protocol_err.
- Head FSM:
  - IDLE: queue empty. Leaves to START when occupancy becomes nonzero.
  - START: cmd_start[head.cmd]=1 for exactly this cycle -> RUN.
  - RUN: wait for cmd_complete[head.cmd] -> DONE.
  - DONE: wb_done=1, wb_id=head.id. On wb_ack: pop; next state START if entries remain after the pop (including a same-cycle push), else IDLE.
- cmd_busy[i] = OR over valid entries of (entry.cmd == i), computed from registered state.
- protocol_err is set, and held until reset, by any of:
  - cmd_complete bit set outside RUN
  - a cmd_complete bit in RUN other than head.cmd
  - wb_ack while wb_done=0
  - a rejected multi-hot request
- Wrong-engine completions are ignored for FSM purposes.
- Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo DEPTH.

## Timing
- Reset values: issue_ready=1, cmd_start=0, cmd_busy=0, wb_done=0, wb_id=0, occupancy=0, protocol_err=0, FSM=IDLE, pointers=0.
- Empty queue, accept at cycle 0: occupancy=1 and FSM=START at cycle 1; cmd_start pulses in cycle 1; RUN from cycle 2.
- A cmd_complete coinciding with the cmd_start cycle is treated as outside RUN and sets protocol_err.
- cmd_complete in cycle k (RUN): wb_done=1 from cycle k+1.
- wb_ack in cycle m (DONE): pop at m+1; if more entries remain, the next cmd_start pulses in cycle m+1.
- Back-to-back throughput: one retirement per 3 cycles minimum (START, RUN with same-cycle complete, DONE with same-cycle ack).
- wb_done remains high until acked; no timeout.
- Reset mid-operation clears all state in one cycle. Engines must be reset concurrently; a stray completion after reset flags protocol_err.

## Test plan
- Single command: issue id=5, cmd=0010 -> cmd_start=0010 at cycle 1, cmd_busy=0010. Complete at cycle 4 -> wb_done=1, wb_id=5 at cycle 5. Ack -> occupancy=0, cmd_busy=0.
- Fill DEPTH=4 with ids 1..4 on engines 0,1,2,0 -> issue_ready=0 at occupancy 4. A 5th request is not accepted. Retirement order is wb_id 1,2,3,4, and cmd_start pulses follow engine order 0,1,2,0.
- Simultaneous push and pop when occupancy=2 -> occupancy stays 2. The pushed entry retires after the existing ones, and pointer wrap-around is exercised over ≥10 commands.
- Error cases -> each sets protocol_err=1, which stays 1 until rst:
  - multi-hot issue_cmd=0011 -> not accepted, occupancy unchanged
  - head engine 1 with cmd_complete=0100 in RUN -> FSM stays RUN
  - wb_ack with wb_done=0
- Reset asserted in RUN with 3 entries queued -> next cycle: occupancy=0, cmd_busy=0, wb_done=0, issue_ready=1, FSM=IDLE. A new issue then proceeds normally.

Source files
------------

// File: rtl/prism_sp_unit_cmd_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : prism_sp_unit_cmd_queue_if
// Purpose : Issue, engine and writeback signals of the PRISM SP command queue.
// Revision: 1.0
// ============================================================================
interface prism_sp_unit_cmd_queue_if #(
  parameter int NUM_CMDS = 4,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                issue_new_request;
  logic [ID_W-1:0]     issue_id;
  logic [NUM_CMDS-1:0] issue_cmd;
  logic                issue_ready;
  logic [NUM_CMDS-1:0] cmd_start;
  logic [NUM_CMDS-1:0] cmd_complete;
  logic [NUM_CMDS-1:0] cmd_busy;
  logic                wb_done;
  logic [ID_W-1:0]     wb_id;
  logic                wb_ack;
  logic [CNT_W-1:0]    occupancy;
  logic                protocol_err;

  modport master (
    output issue_new_request, issue_id, issue_cmd, cmd_complete, wb_ack,
    input  issue_ready, cmd_start, cmd_busy, wb_done, wb_id, occupancy, protocol_err
  );

  modport slave (
    input  issue_new_request, issue_id, issue_cmd, cmd_complete, wb_ack,
    output issue_ready, cmd_start, cmd_busy, wb_done, wb_id, occupancy, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/prism_sp_unit_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module  : prism_sp_unit_cmd_queue
// Purpose : In-order, ID-tagged multi-engine command tracker with error flag.
// Revision: 1.0
// ============================================================================
module prism_sp_unit_cmd_queue #(
  parameter int NUM_CMDS = 4,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 3
) (
  input  wire logic                clk,
  input  wire logic                rst,
  prism_sp_unit_cmd_queue_if.slave q_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     id_mem_q  [DEPTH];
  logic [NUM_CMDS-1:0] cmd_mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    remain_after_pop;
  logic [NUM_CMDS-1:0] cmd_start_q;
  logic                wb_done_q;
  logic [ID_W-1:0]     wb_id_q;
  logic                err_q, err_d;

  logic [NUM_CMDS-1:0] head_cmd;
  logic [NUM_CMDS-1:0] next_head_cmd;
  logic [NUM_CMDS-1:0] busy;
  logic                issue_ready;
  logic                cmd_multihot;
  logic                cmd_onehot;
  logic                push;
  logic                pop;

  assign issue_ready  = (count_q != FULL_CNT);
  assign cmd_multihot = ((q_if.issue_cmd & (q_if.issue_cmd - NUM_CMDS'(1))) != '0);
  assign cmd_onehot   = (q_if.issue_cmd != '0) && !cmd_multihot;
  assign push         = q_if.issue_new_request && issue_ready && cmd_onehot;
  assign pop          = (state_q == S_DONE) && q_if.wb_ack;

  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign remain_after_pop = pop ? count_q - CNT_W'(1) : count_q;
  assign head_cmd         = cmd_mem_q[rd_ptr_q];
  // A push into a queue that is (or is about to be) empty becomes the head
  // before it lands in storage, so take its select straight from the bus.
  assign next_head_cmd    = (remain_after_pop == '0) ? q_if.issue_cmd
                                                     : cmd_mem_q[rd_ptr_d];

  always_comb begin
    err_d = err_q;
    if ((q_if.cmd_complete != '0) && (state_q != S_RUN)) begin
      err_d = 1'b1;
    end
    if ((state_q == S_RUN) && ((q_if.cmd_complete & ~head_cmd) != '0)) begin
      err_d = 1'b1;
    end
    if (q_if.wb_ack && !wb_done_q) begin
      err_d = 1'b1;
    end
    if (q_if.issue_new_request && cmd_multihot) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) begin
        busy = busy | cmd_mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q]  <= q_if.issue_id;
      cmd_mem_q[wr_ptr_q] <= q_if.issue_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cmd_start_q <= '0;
      wb_done_q   <= 1'b0;
      wb_id_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      cmd_start_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (count_d != '0) begin
            state_q     <= S_START;
            cmd_start_q <= next_head_cmd;
          end
        end
        S_START: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if ((q_if.cmd_complete & head_cmd) != '0) begin
            state_q   <= S_DONE;
            wb_done_q <= 1'b1;
            wb_id_q   <= id_mem_q[rd_ptr_q];
          end
        end
        S_DONE: begin
          if (q_if.wb_ack) begin
            wb_done_q <= 1'b0;
            if (count_d != '0) begin
              state_q     <= S_START;
              cmd_start_q <= next_head_cmd;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign q_if.issue_ready  = issue_ready;
  assign q_if.cmd_start    = cmd_start_q;
  assign q_if.cmd_busy     = busy;
  assign q_if.wb_done      = wb_done_q;
  assign q_if.wb_id        = wb_id_q;
  assign q_if.occupancy    = count_q;
  assign q_if.protocol_err = err_q;
endmodule
`default_nettype wire

// File: tb/tb_prism_sp_unit_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_prism_sp_unit_cmd_queue
// Purpose : Directed self-checking bench for the PRISM SP command queue.
// Revision: 1.0
// ============================================================================
module tb_prism_sp_unit_cmd_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  prism_sp_unit_cmd_queue_if #(.NUM_CMDS(4), .DEPTH(4), .ID_W(3)) q_if ();

  prism_sp_unit_cmd_queue #(.NUM_CMDS(4), .DEPTH(4), .ID_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (q_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; single-cycle pulses are dropped after the edge.
  task automatic cyc();
    @(negedge clk);
    q_if.issue_new_request = 1'b0;
    q_if.cmd_complete      = 4'b0000;
    q_if.wb_ack            = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_req(input logic [2:0] id, input logic [3:0] cmd);
    q_if.issue_new_request = 1'b1;
    q_if.issue_id          = id;
    q_if.issue_cmd         = cmd;
  endtask

  logic [6:0] exp_q [$];
  logic [6:0] head;
  logic [3:0] hcmd;
  logic [2:0] nid;
  logic [3:0] ncmd;
  logic [3:0] fill_eng  [4];
  logic [3:0] fill_busy [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    q_if.issue_new_request = 1'b0;
    q_if.issue_id          = 3'd0;
    q_if.issue_cmd         = 4'b0000;
    q_if.cmd_complete      = 4'b0000;
    q_if.wb_ack            = 1'b0;
    cyc();
    do_reset();

    // ---------------- reset values
    chk("rst_ready", 32'(q_if.issue_ready), 1);
    chk("rst_start", 32'(q_if.cmd_start), 0);
    chk("rst_busy",  32'(q_if.cmd_busy), 0);
    chk("rst_done",  32'(q_if.wb_done), 0);
    chk("rst_wbid",  32'(q_if.wb_id), 0);
    chk("rst_occ",   32'(q_if.occupancy), 0);
    chk("rst_err",   32'(q_if.protocol_err), 0);

    // ---------------- single command
    push_req(3'd5, 4'b0010);
    cyc();
    chk("s1_occ1",   32'(q_if.occupancy), 1);
    chk("s1_start",  32'(q_if.cmd_start), 32'b0010);
    chk("s1_busy",   32'(q_if.cmd_busy), 32'b0010);
    cyc();
    chk("s1_start_clr", 32'(q_if.cmd_start), 0);
    cyc();
    cyc();
    chk("s1_done_pre", 32'(q_if.wb_done), 0);
    q_if.cmd_complete = 4'b0010;
    cyc();
    chk("s1_done", 32'(q_if.wb_done), 1);
    chk("s1_wbid", 32'(q_if.wb_id), 5);
    q_if.wb_ack = 1'b1;
    cyc();
    chk("s1_occ0",  32'(q_if.occupancy), 0);
    chk("s1_busy0", 32'(q_if.cmd_busy), 0);
    chk("s1_done0", 32'(q_if.wb_done), 0);
    chk("s1_err",   32'(q_if.protocol_err), 0);

    // ---------------- fill to capacity, in-order retirement
    fill_eng[0]  = 4'b0001; fill_eng[1]  = 4'b0010; fill_eng[2]  = 4'b0100; fill_eng[3]  = 4'b0001;
    fill_busy[0] = 4'b0111; fill_busy[1] = 4'b0101; fill_busy[2] = 4'b0001; fill_busy[3] = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      push_req(3'(k + 1), fill_eng[k]);
      cyc();
      if (k == 0) chk("s2_start0", 32'(q_if.cmd_start), 32'b0001);
    end
    chk("s2_occ4",   32'(q_if.occupancy), 4);
    chk("s2_ready0", 32'(q_if.issue_ready), 0);
    chk("s2_busy",   32'(q_if.cmd_busy), 32'b0111);
    push_req(3'd5, 4'b1000);
    cyc();
    chk("s2_reject_occ",  32'(q_if.occupancy), 4);
    chk("s2_reject_busy", 32'(q_if.cmd_busy), 32'b0111);
    for (int k = 0; k < 4; k++) begin
      q_if.cmd_complete = fill_eng[k];
      cyc();
      chk("s2_done", 32'(q_if.wb_done), 1);
      chk("s2_wbid", 32'(q_if.wb_id), 32'(k + 1));
      q_if.wb_ack = 1'b1;
      cyc();
      chk("s2_busy_after", 32'(q_if.cmd_busy), 32'(fill_busy[k]));
      if (k < 3) begin
        chk("s2_start_next", 32'(q_if.cmd_start), 32'(fill_eng[k + 1]));
        cyc();
      end
    end
    chk("s2_occ0",  32'(q_if.occupancy), 0);
    chk("s2_ready", 32'(q_if.issue_ready), 1);
    chk("s2_err",   32'(q_if.protocol_err), 0);

    // ---------------- push and pop together at occupancy 2, pointer wrap
    exp_q = {};
    push_req(3'd0, 4'b0001);
    exp_q.push_back({3'd0, 4'b0001});
    cyc();
    push_req(3'd1, 4'b0010);
    exp_q.push_back({3'd1, 4'b0010});
    cyc();
    chk("s3_occ2", 32'(q_if.occupancy), 2);
    for (int k = 0; k < 10; k++) begin
      head = exp_q[0];
      hcmd = head[3:0];
      q_if.cmd_complete = hcmd;
      cyc();
      chk("s3_done", 32'(q_if.wb_done), 1);
      chk("s3_wbid", 32'(q_if.wb_id), 32'(head[6:4]));
      nid  = 3'(k + 2);
      ncmd = 4'b0001 << ((k + 2) % 4);
      q_if.wb_ack = 1'b1;
      push_req(nid, ncmd);
      void'(exp_q.pop_front());
      exp_q.push_back({nid, ncmd});
      cyc();
      chk("s3_occ_same", 32'(q_if.occupancy), 2);
      head = exp_q[0];
      hcmd = head[3:0];
      chk("s3_start", 32'(q_if.cmd_start), 32'(hcmd));
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      head = exp_q.pop_front();
      hcmd = head[3:0];
      q_if.cmd_complete = hcmd;
      cyc();
      chk("s3_drain_wbid", 32'(q_if.wb_id), 32'(head[6:4]));
      q_if.wb_ack = 1'b1;
      cyc();
      if (k == 0) begin
        head = exp_q[0];
        hcmd = head[3:0];
        chk("s3_drain_start", 32'(q_if.cmd_start), 32'(hcmd));
        cyc();
      end
    end
    chk("s3_occ0", 32'(q_if.occupancy), 0);
    chk("s3_err",  32'(q_if.protocol_err), 0);

    // ---------------- protocol errors
    push_req(3'd1, 4'b0011);
    cyc();
    chk("e1_occ", 32'(q_if.occupancy), 0);
    chk("e1_err", 32'(q_if.protocol_err), 1);
    chk("e1_nostart", 32'(q_if.cmd_start), 0);
    cyc();
    cyc();
    chk("e1_sticky", 32'(q_if.protocol_err), 1);
    do_reset();
    chk("e1_cleared", 32'(q_if.protocol_err), 0);

    push_req(3'd2, 4'b0010);
    cyc();
    cyc();
    q_if.cmd_complete = 4'b0100;
    cyc();
    chk("e2_err",  32'(q_if.protocol_err), 1);
    chk("e2_done", 32'(q_if.wb_done), 0);
    q_if.cmd_complete = 4'b0010;
    cyc();
    chk("e2_still_run", 32'(q_if.wb_done), 1);
    chk("e2_wbid", 32'(q_if.wb_id), 2);
    q_if.wb_ack = 1'b1;
    cyc();
    chk("e2_occ0",   32'(q_if.occupancy), 0);
    chk("e2_sticky", 32'(q_if.protocol_err), 1);
    do_reset();

    q_if.wb_ack = 1'b1;
    cyc();
    chk("e3_err", 32'(q_if.protocol_err), 1);
    do_reset();

    push_req(3'd3, 4'b0001);
    cyc();
    q_if.cmd_complete = 4'b0001;
    cyc();
    chk("e4_err_start", 32'(q_if.protocol_err), 1);
    do_reset();

    q_if.cmd_complete = 4'b1000;
    cyc();
    chk("e5_err_idle", 32'(q_if.protocol_err), 1);
    do_reset();

    // ---------------- reset in RUN with three entries
    push_req(3'd1, 4'b0001);
    cyc();
    push_req(3'd2, 4'b0010);
    cyc();
    push_req(3'd3, 4'b0100);
    cyc();
    chk("r_occ3", 32'(q_if.occupancy), 3);
    do_reset();
    chk("r_occ",   32'(q_if.occupancy), 0);
    chk("r_busy",  32'(q_if.cmd_busy), 0);
    chk("r_done",  32'(q_if.wb_done), 0);
    chk("r_ready", 32'(q_if.issue_ready), 1);
    chk("r_start", 32'(q_if.cmd_start), 0);
    chk("r_err",   32'(q_if.protocol_err), 0);
    push_req(3'd6, 4'b1000);
    cyc();
    chk("r_new_start", 32'(q_if.cmd_start), 32'b1000);
    chk("r_new_occ",   32'(q_if.occupancy), 1);
    cyc();
    q_if.cmd_complete = 4'b1000;
    cyc();
    chk("r_new_done", 32'(q_if.wb_done), 1);
    chk("r_new_wbid", 32'(q_if.wb_id), 6);
    q_if.wb_ack = 1'b1;
    cyc();
    chk("r_new_occ0", 32'(q_if.occupancy), 0);
    chk("r_new_err",  32'(q_if.protocol_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
